aes_round_tail: RTL

//  Registered back half of one AES-128 encryption round; sits directly downstream of SubBytes.

---
 rtl/aes_round_tail_if.sv | 23 ++
 rtl/aes_round_tail.sv | 99 +++++++++
 2 files changed

// File: rtl/aes_round_tail_if.sv
// Valid/ready bus for the AES round tail: SubBytes state + round key in, round result out.
// Byte k of every 128-bit field sits at bits [8k +: 8], k = row + 4*column.
interface aes_round_tail_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic [0:127] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;
    logic         out_last;

    modport master (
        output in_valid, in_state, in_key, in_last, out_ready,
        input  in_ready, out_valid, out_state, out_last
    );

    modport slave (
        input  in_valid, in_state, in_key, in_last, out_ready,
        output in_ready, out_valid, out_state, out_last
    );
endinterface

// File: rtl/aes_round_tail.sv
// Back half of an AES-128 encryption round (ShiftRows, MixColumns, AddRoundKey)
// feeding a small output FIFO so the round controller can stall freely.

module aes_mix_col (
    input  logic [0:31] col_in,
    input  logic        bypass,
    output logic [0:31] col_out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] b0, b1, b2, b3;
    logic [7:0] m0, m1, m2, m3;

    assign b0 = col_in[0  +: 8];
    assign b1 = col_in[8  +: 8];
    assign b2 = col_in[16 +: 8];
    assign b3 = col_in[24 +: 8];

    // 3*b is written as xt(b)^b.
    assign m0 = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
    assign m1 = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
    assign m2 = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
    assign m3 = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);

    assign col_out = bypass ? col_in : {m0, m1, m2, m3};
endmodule

module aes_round_tail #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_tail_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic         last;
        logic [0:127] state;
    } entry_t;

    logic [0:127] sr, mc, rk;

    // ShiftRows: row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
        for (genvar r = 0; r < 4; r++) begin : g_sr_row
            assign sr[8*(r+4*c) +: 8] = bus.in_state[8*(r+4*((c+r)%4)) +: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mc
        aes_mix_col u_col (
            .col_in (sr[32*c +: 32]),
            .bypass (bus.in_last),
            .col_out(mc[32*c +: 32])
        );
    end

    assign rk = mc ^ bus.in_key;

    entry_t [DEPTH-1:0] mem;
    logic   [PW-1:0]    wr_ptr, rd_ptr;
    logic   [CW-1:0]    count;
    logic               push, pop;

    // in_ready comes from registered count only, so out_ready never reaches it.
    assign bus.in_ready  = (count != CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.out_state = mem[rd_ptr].state;
    assign bus.out_last  = mem[rd_ptr].last;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr].state <= rk;
                mem[wr_ptr].last  <= bus.in_last;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
